grover_iterate_unit: RTL and testbench

//  One Grover iteration on the 8-amplitude (3-qubit) state held in the amplitude register bank.
//  - Sits directly downstream of the bank; its o0..o7 and done feed back to the bank's i0..i7 and en.
//  - Oracle: negate amplitude[marked].
//  - Diffusion: a_k' = 2*mean - a_k.
//  - Amplitudes are processed serially through one shared adder; results are published as one vector.

---
 rtl/grover_pkg.sv | 27 ++
 rtl/grover_iterate_unit_if.sv | 23 ++
 rtl/grover_sat.sv | 27 ++
 rtl/grover_iterate_unit.sv | 138 +++++++++++++
 tb/tb_grover_iterate_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/grover_pkg.sv
// Shared types, sizes and the amplitude clamp for the Grover iteration unit.
package grover_pkg;

   localparam int AMP_W_DEF = 8;
   localparam int N_AMP     = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_MEAN,
      S_REFLECT,
      S_DONE
   } state_t;

   // Clamp an (AMP_W_DEF+3)-bit signed value into the AMP_W_DEF-bit signed range.
   function automatic logic signed [AMP_W_DEF-1:0] sat(input logic signed [AMP_W_DEF+2:0] v);
      logic signed [AMP_W_DEF+2:0] max_v;
      logic signed [AMP_W_DEF+2:0] min_v;
      max_v = {{4{1'b0}}, {(AMP_W_DEF-1){1'b1}}};
      min_v = {{4{1'b1}}, {(AMP_W_DEF-1){1'b0}}};
      if (v > max_v)      sat = max_v[AMP_W_DEF-1:0];
      else if (v < min_v) sat = min_v[AMP_W_DEF-1:0];
      else                sat = v[AMP_W_DEF-1:0];
   endfunction

endpackage

// File: rtl/grover_iterate_unit_if.sv
// Handshake and amplitude vector bundle between the amplitude bank and the iterate unit.
interface grover_iterate_unit_if
   import grover_pkg::*;
#(
   parameter int AMP_W = AMP_W_DEF
);
   logic                    start;
   logic [IDX_W-1:0]        marked;
   logic signed [AMP_W-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
   logic signed [AMP_W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic                    busy;
   logic                    done;

   modport master (
      output start, marked, i0, i1, i2, i3, i4, i5, i6, i7,
      input  o0, o1, o2, o3, o4, o5, o6, o7, busy, done
   );

   modport slave (
      input  start, marked, i0, i1, i2, i3, i4, i5, i6, i7,
      output o0, o1, o2, o3, o4, o5, o6, o7, busy, done
   );
endinterface

// File: rtl/grover_sat.sv
// Combinational (AMP_W+3)-bit to AMP_W-bit narrowing: clamp when SAT_EN, plain truncation otherwise.
module grover_sat #(
   parameter int AMP_W  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic signed [AMP_W+2:0] din,
   output logic signed [AMP_W-1:0] dout
);

   localparam logic signed [AMP_W+2:0] MAX_V = {{4{1'b0}}, {(AMP_W-1){1'b1}}};
   localparam logic signed [AMP_W+2:0] MIN_V = {{4{1'b1}}, {(AMP_W-1){1'b0}}};

   function automatic logic signed [AMP_W-1:0] sat_w(input logic signed [AMP_W+2:0] v);
      if (v > MAX_V)      sat_w = MAX_V[AMP_W-1:0];
      else if (v < MIN_V) sat_w = MIN_V[AMP_W-1:0];
      else                sat_w = v[AMP_W-1:0];
   endfunction

   generate
      if (SAT_EN) begin : g_sat
         assign dout = sat_w(din);
      end else begin : g_wrap
         assign dout = din[AMP_W-1:0];
      end
   endgenerate

endmodule

// File: rtl/grover_iterate_unit.sv
// One Grover iteration (oracle flip + inversion about the mean) over 8 amplitudes,
// processed serially through a single adder and published as one vector on done.
module grover_iterate_unit
   import grover_pkg::*;
#(
   parameter int AMP_W  = AMP_W_DEF,
   parameter bit SAT_EN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   grover_iterate_unit_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_AMP - 1);

   state_t                  state, state_n;
   logic                    accept;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        mk;
   logic signed [AMP_W+3:0] sum;
   logic signed [AMP_W+3:0] sum_sh;
   logic signed [AMP_W:0]   mean;
   logic signed [AMP_W:0]   amp_buf [N_AMP];
   logic signed [AMP_W-1:0] res_q   [N_AMP];
   logic signed [AMP_W-1:0] o_q     [N_AMP];
   logic signed [AMP_W-1:0] in_v    [N_AMP];
   logic signed [AMP_W:0]   cur, x;
   logic signed [AMP_W+2:0] r;
   logic signed [AMP_W-1:0] r_sat;

   assign in_v[0] = bus.i0;
   assign in_v[1] = bus.i1;
   assign in_v[2] = bus.i2;
   assign in_v[3] = bus.i3;
   assign in_v[4] = bus.i4;
   assign in_v[5] = bus.i5;
   assign in_v[6] = bus.i6;
   assign in_v[7] = bus.i7;

   assign bus.o0 = o_q[0];
   assign bus.o1 = o_q[1];
   assign bus.o2 = o_q[2];
   assign bus.o3 = o_q[3];
   assign bus.o4 = o_q[4];
   assign bus.o5 = o_q[5];
   assign bus.o6 = o_q[6];
   assign bus.o7 = o_q[7];

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         S_IDLE: begin
            accept = bus.start;
            if (bus.start) state_n = S_ACCUM;
         end
         S_ACCUM: begin
            bus.busy = 1'b1;
            if (idx == LAST) state_n = S_MEAN;
         end
         S_MEAN: begin
            bus.busy = 1'b1;
            state_n  = S_REFLECT;
         end
         S_REFLECT: begin
            bus.busy = 1'b1;
            if (idx == LAST) state_n = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            accept   = bus.start;
            state_n  = bus.start ? S_ACCUM : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Shared datapath: oracle negation (AMP_W+1 bits) and reflection (AMP_W+3 bits).
   assign cur    = amp_buf[idx];
   assign x      = (idx == mk) ? -cur : cur;
   assign sum_sh = sum >>> 3;
   assign r      = {mean[AMP_W], mean, 1'b0} - {{2{cur[AMP_W]}}, cur};

   grover_sat #(.AMP_W(AMP_W), .SAT_EN(SAT_EN)) u_sat (
      .din  (r),
      .dout (r_sat)
   );

   // Control-side registers: reset-cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         sum <= '0;
         for (int k = 0; k < N_AMP; k++) o_q[k] <= '0;
      end else if (accept) begin
         idx <= '0;
         sum <= '0;
      end else begin
         case (state)
            S_ACCUM: begin
               sum <= sum + {{3{x[AMP_W]}}, x};
               idx <= idx + IDX_W'(1);
            end
            S_MEAN: idx <= '0;
            S_REFLECT: begin
               idx <= idx + IDX_W'(1);
               // The last result is taken straight from the saturator so the
               // whole vector lands on the edge that enters DONE.
               if (idx == LAST) begin
                  for (int k = 0; k < N_AMP; k++)
                     o_q[k] <= (k == N_AMP - 1) ? r_sat : res_q[k];
               end
            end
            default: ;
         endcase
      end
   end

   // Data-side registers: no reset, only written under control of the FSM.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < N_AMP; k++) amp_buf[k] <= {in_v[k][AMP_W-1], in_v[k]};
         mk <= bus.marked;
      end else if (state == S_ACCUM) begin
         amp_buf[idx] <= x;
      end
      if (state == S_MEAN)    mean       <= sum_sh[AMP_W:0];
      if (state == S_REFLECT) res_q[idx] <= r_sat;
   end

endmodule

// File: tb/tb_grover_iterate_unit.sv
// Self-checking bench for grover_iterate_unit: directed table, corner sequences, randomized model checks.
module tb_grover_iterate_unit;
   import grover_pkg::*;

   typedef int arr8_t [8];
   typedef struct {
      arr8_t a;
      int    m;
      arr8_t e;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   grover_iterate_unit_if #(.AMP_W(8)) bus();

   grover_iterate_unit #(.AMP_W(8), .SAT_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, got, exp);
   endtask

   // Reference: flip the marked amplitude, reflect about the floored mean, clamp to 8 bits.
   function automatic void model(input arr8_t a, input int m, output arr8_t r);
      int x [8];
      int s;
      int mean;
      int v;
      s = 0;
      for (int k = 0; k < 8; k++) begin
         x[k] = (k == m) ? -a[k] : a[k];
         s += x[k];
      end
      mean = s >>> 3;
      for (int k = 0; k < 8; k++) begin
         v = 2 * mean - x[k];
         r[k] = (v > 127) ? 127 : ((v < -128) ? -128 : v);
      end
   endfunction

   task automatic set_in(input arr8_t a);
      bus.i0 = 8'(a[0]); bus.i1 = 8'(a[1]); bus.i2 = 8'(a[2]); bus.i3 = 8'(a[3]);
      bus.i4 = 8'(a[4]); bus.i5 = 8'(a[5]); bus.i6 = 8'(a[6]); bus.i7 = 8'(a[7]);
   endtask

   task automatic get_o(output arr8_t r);
      r[0] = int'(bus.o0); r[1] = int'(bus.o1); r[2] = int'(bus.o2); r[3] = int'(bus.o3);
      r[4] = int'(bus.o4); r[5] = int'(bus.o5); r[6] = int'(bus.o6); r[7] = int'(bus.o7);
   endtask

   task automatic kick(input arr8_t a, input int m);
      set_in(a);
      bus.marked = 3'(m);
      bus.start  = 1'b1;
   endtask

   // Called on the negedge where start was raised; returns on the done negedge (or budget).
   task automatic wait_done(output int n);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", int'(bus.busy), 1);
      n = 1;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_vec(input string name, input arr8_t got, input arr8_t exp);
      for (int k = 0; k < 8; k++)
         check($sformatf("%s_o%0d", name, k), got[k], exp[k]);
   endtask

   initial begin
      vec_t  tbl [3];
      arr8_t got, exp, s1a, s1e, a;
      int    n, dones, first, m;

      n_pass  = 0;
      n_total = 0;
      for (int k = 0; k < 8; k++) begin
         tbl[0].a[k] = 22;   tbl[0].e[k] = (k == 5) ? 54 : 10;
         tbl[1].a[k] = 127;  tbl[1].e[k] = (k == 0) ? 127 : 63;
         tbl[2].a[k] = -128; tbl[2].e[k] = (k == 3) ? -128 : -64;
      end
      tbl[0].m = 5;
      tbl[1].m = 0;
      tbl[2].m = 3;
      s1a = tbl[0].a;
      s1e = tbl[0].e;

      rst = 1'b1;
      bus.start  = 1'b0;
      bus.marked = '0;
      set_in(s1a);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      get_o(got);
      for (int k = 0; k < 8; k++) check($sformatf("reset_o%0d", k), got[k], 0);

      for (int t = 0; t < 3; t++) begin
         kick(tbl[t].a, tbl[t].m);
         wait_done(n);
         check($sformatf("tbl%0d_latency", t), n, 18);
         get_o(got);
         check_vec($sformatf("tbl%0d", t), got, tbl[t].e);
         @(negedge clk);
         check($sformatf("tbl%0d_done_pulse", t), int'(bus.done), 0);
         check($sformatf("tbl%0d_busy_idle", t), int'(bus.busy), 0);
      end

      // Back-to-back: feed results back and restart in the done cycle.
      kick(s1a, 5);
      wait_done(n);
      check("b2b_first_latency", n, 18);
      get_o(got);
      kick(got, 5);
      wait_done(n);
      check("b2b_second_latency", n, 18);
      get_o(got);
      for (int k = 0; k < 8; k++) exp[k] = (k == 5) ? 58 : -6;
      check_vec("b2b", got, exp);
      @(negedge clk);
      check("b2b_busy_idle", int'(bus.busy), 0);

      // Start pulses while busy must be ignored.
      kick(s1a, 5);
      dones = 0;
      first = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dones++;
            if (first == 0) begin
               first = c;
               get_o(got);
            end
         end
         set_in(tbl[1].a);
         bus.start = (c == 3 || c == 12) ? 1'b1 : 1'b0;
      end
      check("busy_start_done_count", dones, 1);
      check("busy_start_latency", first, 18);
      check_vec("busy_start", got, s1e);

      // Reset in the middle of an iteration.
      kick(tbl[1].a, 0);
      dones = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) dones++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", int'(bus.busy), 0);
      get_o(got);
      for (int k = 0; k < 8; k++) check($sformatf("midrst_o%0d", k), got[k], 0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("midrst_no_done", dones, 0);

      // Randomized iterations against the reference model.
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < 8; k++) a[k] = int'($urandom_range(255)) - 128;
         if (t % 6 == 0) for (int k = 0; k < 8; k++) a[k] = (t % 12 == 0) ? 127 : -128;
         m = int'($urandom_range(7));
         model(a, m, exp);
         kick(a, m);
         wait_done(n);
         check($sformatf("rnd%0d_latency", t), n, 18);
         get_o(got);
         check_vec($sformatf("rnd%0d", t), got, exp);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
